screen_fill_drawer: RTL and testbench

//  Responder side of the top-level draw handshake: paints one full screen
//  (homescreen / game-over) into the VGA adapter when the top controller requests it.

---
 rtl/screen_fill_drawer_if.sv | 22 ++
 rtl/screen_fill_drawer.sv | 135 +++++++++++++
 tb/tb_screen_fill_drawer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/screen_fill_drawer_if.sv
// Draw handshake between the top controller and the full-screen painter,
// together with the pixel stream the painter sends to the drawable mux.
interface screen_fill_drawer_if;
    logic       draw_req;
    logic [2:0] bg_col;
    logic [2:0] fg_col;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] col_out;
    logic       plot;
    logic       drawn;

    modport master (
        output draw_req, bg_col, fg_col,
        input  x_out, y_out, col_out, plot, drawn
    );

    modport slave (
        input  draw_req, bg_col, fg_col,
        output x_out, y_out, col_out, plot, drawn
    );
endinterface

// File: rtl/screen_fill_drawer.sv
// Paints a full screen as a raster sweep, one pixel per cycle: background
// colour everywhere with a foreground box overlaid; reports completion via drawn.
module screen_fill_drawer #(
    parameter int unsigned SCR_W  = 160,
    parameter int unsigned SCR_H  = 120,
    parameter int unsigned BOX_X0 = 40,
    parameter int unsigned BOX_X1 = 119,
    parameter int unsigned BOX_Y0 = 40,
    parameter int unsigned BOX_Y1 = 79
) (
    input  logic                  clk,
    input  logic                  resetn,
    screen_fill_drawer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_X = 8'(SCR_W - 1);
    localparam logic [6:0] LAST_Y = 7'(SCR_H - 1);
    localparam logic [7:0] BX0    = 8'(BOX_X0);
    localparam logic [7:0] BX1    = 8'(BOX_X1);
    localparam logic [6:0] BY0    = 7'(BOX_Y0);
    localparam logic [6:0] BY1    = 7'(BOX_Y1);

    state_t     state_q, state_d;
    logic [7:0] x_cnt_q, x_cnt_d;
    logic [6:0] y_cnt_q, y_cnt_d;
    logic [2:0] bg_q, bg_d;
    logic [2:0] fg_q, fg_d;
    logic [7:0] x_out_q, x_out_d;
    logic [6:0] y_out_q, y_out_d;
    logic [2:0] col_q, col_d;
    logic       plot_q, plot_d;
    logic       drawn_q, drawn_d;
    logic       in_box;

    always_comb begin
        state_d = state_q;
        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        bg_d    = bg_q;
        fg_d    = fg_q;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        col_d   = col_q;
        plot_d  = 1'b0;
        drawn_d = 1'b0;

        in_box = (x_cnt_q >= BX0) && (x_cnt_q <= BX1) &&
                 (y_cnt_q >= BY0) && (y_cnt_q <= BY1);

        case (state_q)
            IDLE: begin
                if (bus.draw_req) begin
                    state_d = DRAW;
                    bg_d    = bus.bg_col;
                    fg_d    = bus.fg_col;
                    x_cnt_d = '0;
                    y_cnt_d = '0;
                end
            end
            DRAW: begin
                if (!bus.draw_req) begin
                    state_d = IDLE;
                    x_cnt_d = '0;
                    y_cnt_d = '0;
                end else begin
                    plot_d  = 1'b1;
                    x_out_d = x_cnt_q;
                    y_out_d = y_cnt_q;
                    col_d   = in_box ? fg_q : bg_q;
                    // Explicit end-of-line/frame compares; counters never wrap by overflow.
                    if (x_cnt_q == LAST_X) begin
                        x_cnt_d = '0;
                        if (y_cnt_q == LAST_Y) begin
                            y_cnt_d = '0;
                            state_d = DONE;
                        end else begin
                            y_cnt_d = y_cnt_q + 7'd1;
                        end
                    end else begin
                        x_cnt_d = x_cnt_q + 8'd1;
                    end
                end
            end
            DONE: begin
                if (bus.draw_req) begin
                    drawn_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            bg_q    <= '0;
            fg_q    <= '0;
            x_out_q <= '0;
            y_out_q <= '0;
            col_q   <= '0;
            plot_q  <= 1'b0;
            drawn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
            bg_q    <= bg_d;
            fg_q    <= fg_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
            col_q   <= col_d;
            plot_q  <= plot_d;
            drawn_q <= drawn_d;
        end
    end

    assign bus.x_out   = x_out_q;
    assign bus.y_out   = y_out_q;
    assign bus.col_out = col_q;
    assign bus.plot    = plot_q;
    assign bus.drawn   = drawn_q;

endmodule

// File: tb/tb_screen_fill_drawer.sv
// Scoreboard bench for screen_fill_drawer: default-size instance plus a 4x3 instance.
module tb_screen_fill_drawer;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic [17:0] exp_q[$];

    always #10 clk = ~clk;

    screen_fill_drawer_if bif ();
    screen_fill_drawer_if sif ();

    screen_fill_drawer dut_big (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    screen_fill_drawer #(
        .SCR_W  (4),
        .SCR_H  (3),
        .BOX_X0 (1),
        .BOX_X1 (2),
        .BOX_Y0 (1),
        .BOX_Y1 (1)
    ) dut_small (
        .clk    (clk),
        .resetn (resetn),
        .bus    (sif)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] model_col(input int x, input int y, input int x0, input int x1,
                                             input int y0, input int y1,
                                             input logic [2:0] bg, input logic [2:0] fg);
        if (x >= x0 && x <= x1 && y >= y0 && y <= y1) return fg;
        return bg;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // abort_idx / reset_idx / chg_idx: pixel index at which to drop draw_req,
    // pulse reset, or change bg_col (-1 = never).
    task automatic big_paint(input logic [2:0] bg, input logic [2:0] fg,
                             input int abort_idx, input int reset_idx, input int chg_idx);
        int npix;
        logic [17:0] got;
        logic [17:0] e;
        exp_q.delete();
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                exp_q.push_back({8'(x), 7'(y), model_col(x, y, 40, 119, 40, 79, bg, fg)});
        bif.bg_col   = bg;
        bif.fg_col   = fg;
        bif.draw_req = 1'b1;
        tick;
        check("first_edge_idle", {30'd0, bif.plot, bif.drawn}, 32'd0);
        npix = 0;
        for (int i = 0; i < 19200; i++) begin
            tick;
            check("plot_high", {31'd0, bif.plot}, 32'd1);
            if (!bif.plot) break;
            npix++;
            got = {bif.x_out, bif.y_out, bif.col_out};
            e   = exp_q.pop_front();
            check("pixel", {14'd0, got}, {14'd0, e});
            if (got[17:3] == {8'd39, 7'd40})  check("edge_39_40",  {29'd0, got[2:0]}, {29'd0, bg});
            if (got[17:3] == {8'd40, 7'd40})  check("edge_40_40",  {29'd0, got[2:0]}, {29'd0, fg});
            if (got[17:3] == {8'd119, 7'd79}) check("edge_119_79", {29'd0, got[2:0]}, {29'd0, fg});
            if (got[17:3] == {8'd120, 7'd79}) check("edge_120_79", {29'd0, got[2:0]}, {29'd0, bg});
            if (got[17:3] == {8'd40, 7'd80})  check("edge_40_80",  {29'd0, got[2:0]}, {29'd0, bg});
            if (i == 19199) check("drawn_at_last", {31'd0, bif.drawn}, 32'd0);
            if (i == chg_idx) bif.bg_col = 3'b111;
            if (i == abort_idx) begin
                bif.draw_req = 1'b0;
                tick;
                check("abort_plot",  {31'd0, bif.plot},  32'd0);
                check("abort_drawn", {31'd0, bif.drawn}, 32'd0);
                exp_q.delete();
                return;
            end
            if (i == reset_idx) begin
                resetn = 1'b0;
                tick;
                tick;
                check("reset_outs", {13'd0, bif.plot, bif.drawn, bif.x_out, bif.y_out, bif.col_out}, 32'd0);
                bif.draw_req = 1'b0;
                resetn       = 1'b1;
                tick;
                check("post_reset_plot", {31'd0, bif.plot}, 32'd0);
                exp_q.delete();
                return;
            end
        end
        check("plot_count", npix, 19200);
        tick;
        check("drawn_rise", {31'd0, bif.drawn}, 32'd1);
        check("done_plot",  {31'd0, bif.plot},  32'd0);
        check("sb_left", exp_q.size(), 0);
    endtask

    task automatic small_paint(input logic [2:0] bg, input logic [2:0] fg);
        logic [17:0] got;
        logic [17:0] e;
        exp_q.delete();
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                exp_q.push_back({8'(x), 7'(y), model_col(x, y, 1, 2, 1, 1, bg, fg)});
        sif.bg_col   = bg;
        sif.fg_col   = fg;
        sif.draw_req = 1'b1;
        tick;
        check("s_first_edge_idle", {30'd0, sif.plot, sif.drawn}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick;
            check("s_plot_high", {31'd0, sif.plot}, 32'd1);
            if (!sif.plot) break;
            got = {sif.x_out, sif.y_out, sif.col_out};
            e   = exp_q.pop_front();
            check("s_pixel", {14'd0, got}, {14'd0, e});
            if (i == 3) check("s_wrap_from", {17'd0, got[17:3]}, {17'd0, 8'd3, 7'd0});
            if (i == 4) check("s_wrap_to",   {17'd0, got[17:3]}, {17'd0, 8'd0, 7'd1});
        end
        tick;
        check("s_drawn_rise", {31'd0, sif.drawn}, 32'd1);
        check("s_done_plot",  {31'd0, sif.plot},  32'd0);
        check("s_sb_left", exp_q.size(), 0);
        sif.draw_req = 1'b0;
        tick;
        check("s_drawn_fall", {31'd0, sif.drawn}, 32'd0);
    endtask

    initial begin
        bif.draw_req = 1'b0;
        bif.bg_col   = 3'b000;
        bif.fg_col   = 3'b000;
        sif.draw_req = 1'b0;
        sif.bg_col   = 3'b000;
        sif.fg_col   = 3'b000;
        resetn       = 1'b0;
        tick;
        tick;
        check("init_reset_big",   {13'd0, bif.plot, bif.drawn, bif.x_out, bif.y_out, bif.col_out}, 32'd0);
        check("init_reset_small", {13'd0, sif.plot, sif.drawn, sif.x_out, sif.y_out, sif.col_out}, 32'd0);
        resetn = 1'b1;
        tick;

        // Reset mid-sweep
        big_paint(3'b001, 3'b110, -1, 100, -1);
        tick;

        // Full paint with defaults, then hold draw_req in DONE
        big_paint(3'b001, 3'b110, -1, -1, -1);
        for (int i = 0; i < 50; i++) begin
            tick;
            check("hold_drawn", {31'd0, bif.drawn}, 32'd1);
            check("hold_plot",  {31'd0, bif.plot},  32'd0);
        end
        bif.draw_req = 1'b0;
        tick;
        check("drawn_fall", {31'd0, bif.drawn}, 32'd0);

        // Re-raise: fresh sweep from (0,0), aborted at pixel (10,5)
        big_paint(3'b001, 3'b110, 5 * 160 + 10, -1, -1);
        tick;

        // Restart after abort: full sweep, bg_col changed at pixel (0,60)
        big_paint(3'b001, 3'b110, -1, -1, 60 * 160);
        bif.draw_req = 1'b0;
        tick;
        check("final_drawn_fall", {31'd0, bif.drawn}, 32'd0);

        small_paint(3'b010, 3'b101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
